// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: FSM states, access size codes and the LED address shared by the data memory responder.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

    // sign_mask[1:0]: 00 byte, 01 half, 1x word
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    localparam logic [13:0] LED_ADDR = 14'h2000;

    function automatic logic [1:0] align_lo(input logic [1:0] lo, input logic [2:0] m);
        return m[1] ? 2'b00 : (m[1:0] == SZ_HALF) ? {lo[1], 1'b0} : lo;
    endfunction

    function automatic logic is_led(input logic [13:0] a);
        return (a & LED_ADDR) != '0;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: CPU-side load/store bus of the data memory responder.
interface data_mem_responder_if;
    logic [13:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [2:0]  sign_mask;
    logic [31:0] read_data;
    logic        clk_stall;
    logic        misaligned;
    logic [7:0]  led;

    modport master (
        output addr, write_data, memwrite, memread, sign_mask,
        input  read_data, clk_stall, misaligned, led
    );

    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask,
        output read_data, clk_stall, misaligned, led
    );
endinterface

// File: rtl/data_mem_lane_merge.sv
// data_mem_lane_merge: combinational store-lane merge and load extract/extend for one 32-bit word.
module data_mem_lane_merge
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] write_data,
    input  logic [1:0]  lo,
    input  logic [2:0]  sign_mask,
    output logic [31:0] merged,
    output logic [31:0] extracted
);
    logic [4:0]  sh;
    logic [31:0] lane_mask;
    logic [31:0] shifted;
    logic        byte_sz;
    logic        half_sz;

    always_comb begin
        byte_sz   = sign_mask[1:0] == SZ_BYTE;
        half_sz   = sign_mask[1:0] == SZ_HALF;
        sh        = {lo, 3'b000};
        lane_mask = byte_sz ? 32'h0000_00FF << sh : half_sz ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
        merged    = (word & ~lane_mask) | ((write_data << sh) & lane_mask);
        shifted   = word >> sh;
        extracted = byte_sz ? {{24{sign_mask[2] & shifted[7]}}, shifted[7:0]}
                  : half_sz ? {{16{sign_mask[2] & shifted[15]}}, shifted[15:0]}
                  : word;
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle read-modify-write data RAM with a memory-mapped LED register,
// stalling the CPU until each load or store completes.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WORDS = 1024
) (
    input logic clk,
    input logic reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(WORDS);

    state_t      state, state_next;
    logic        req;
    logic [13:0] lat_addr;
    logic [31:0] lat_data;
    logic [2:0]  lat_mask;
    logic        lat_write;
    logic [31:0] ram_q;
    logic [31:0] merged_q;
    logic [31:0] merged;
    logic [31:0] extracted;
    logic [AW-1:0] idx;
    logic [31:0] ram [WORDS];

    assign req = bus.memread | bus.memwrite;
    assign idx = AW'(lat_addr[11:2]);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state == IDLE  ? (req ? READ : IDLE)
                   : state == READ  ? MERGE
                   : state == MERGE ? (lat_write ? WRITE : IDLE)
                   : IDLE;
    end

    always_comb begin
        bus.clk_stall  = !reset && (state != IDLE || req);
        bus.misaligned = !reset && state == IDLE && req &&
                         bus.addr[1:0] != align_lo(bus.addr[1:0], bus.sign_mask);
    end

    // Misaligned requests are stored already aligned, so the rest of the pipe never sees them.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            lat_addr  <= {bus.addr[13:2], align_lo(bus.addr[1:0], bus.sign_mask)};
            lat_data  <= bus.write_data;
            lat_mask  <= bus.sign_mask;
            lat_write <= bus.memwrite;
        end
        if (state == MERGE) merged_q <= merged;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.read_data <= '0;
            bus.led       <= '0;
        end else begin
            if (state == MERGE && !lat_write)
                bus.read_data <= is_led(lat_addr) ? {24'b0, bus.led} : extracted;
            if (state == WRITE && is_led(lat_addr))
                bus.led <= lat_data[7:0];
        end
    end

    // RAM is never cleared; reset only suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (state == READ) ram_q <= ram[idx];
        if (!reset && state == WRITE && !is_led(lat_addr)) ram[idx] <= merged_q;
    end

    data_mem_lane_merge u_lane (
        .word       (ram_q),
        .write_data (lat_data),
        .lo         (lat_addr[1:0]),
        .sign_mask  (lat_mask),
        .merged     (merged),
        .extracted  (extracted)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench; a byte-level memory model predicts stalls, misaligned pulses,
// read_data and led for every access.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;

    data_mem_responder_if bus();

    data_mem_responder #(.WORDS(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stalls;
        int          mis;
        logic [31:0] rd;
        logic [7:0]  led;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [int];
    logic [7:0]  led_m = 8'h00;
    logic [31:0] rd_m = 32'h0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model(input bit w, input logic [13:0] a, input logic [31:0] d, input logic [2:0] m);
        int          size;
        int          wi;
        int          base;
        logic [13:0] ea;
        logic [31:0] word;
        logic [31:0] v;
        exp_t        e;
        size = m[1] ? 4 : m[0] ? 2 : 1;
        ea   = a & ~14'(size - 1);
        wi   = int'(ea[11:2]);
        base = int'(ea[1:0]);
        e.stalls = w ? 4 : 3;
        e.mis    = (ea != a) ? 1 : 0;
        if (w) begin
            if (a[13]) led_m = d[7:0];
            else begin
                word = mem_m[wi];
                for (int k = 0; k < size; k++) word[(base + k) * 8 +: 8] = d[k * 8 +: 8];
                mem_m[wi] = word;
            end
        end else begin
            if (a[13]) rd_m = {24'b0, led_m};
            else begin
                word = mem_m[wi];
                v = '0;
                for (int k = 0; k < size; k++) v[k * 8 +: 8] = word[(base + k) * 8 +: 8];
                if (m[2] && v[size * 8 - 1])
                    for (int k = size; k < 4; k++) v[k * 8 +: 8] = 8'hFF;
                rd_m = v;
            end
        end
        e.rd  = rd_m;
        e.led = led_m;
        sb.push_back(e);
    endtask

    task automatic op(input bit w, input bit r, input logic [13:0] a, input logic [31:0] d, input logic [2:0] m);
        int   st;
        int   mi;
        exp_t e;
        st = 0;
        mi = 0;
        model(w, a, d, m);
        @(negedge clk);
        bus.addr = a;
        bus.write_data = d;
        bus.memwrite = w;
        bus.memread = r;
        bus.sign_mask = m;
        #1;
        for (int i = 0; i < 12 && bus.clk_stall; i++) begin
            st++;
            if (bus.misaligned) mi++;
            @(posedge clk);
            #1;
            bus.memwrite = 1'b0;
            bus.memread = 1'b0;
            @(negedge clk);
        end
        bus.memwrite = 1'b0;
        bus.memread = 1'b0;
        e = sb.pop_front();
        chk("stall_cycles", 32'(st), 32'(e.stalls));
        chk("misaligned_pulses", 32'(mi), 32'(e.mis));
        chk("read_data", bus.read_data, e.rd);
        chk("led", {24'b0, bus.led}, {24'b0, e.led});
    endtask

    initial begin
        bus.addr = 14'h0001;
        bus.write_data = '0;
        bus.memwrite = 1'b0;
        bus.memread = 1'b1;
        bus.sign_mask = 3'b101;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {31'b0, bus.clk_stall}, 32'h0);
        chk("reset_misaligned", {31'b0, bus.misaligned}, 32'h0);
        chk("reset_read_data", bus.read_data, 32'h0);
        chk("reset_led", {24'b0, bus.led}, 32'h0);
        bus.memread = 1'b0;
        reset = 1'b0;

        op(1, 0, 14'h0000, 32'hCAFE_F00D, 3'b010);
        op(1, 0, 14'h0010, 32'hDEAD_BEEF, 3'b010);
        op(0, 1, 14'h0010, 32'h0, 3'b010);
        op(1, 0, 14'h0010, 32'h1122_3344, 3'b010);
        op(1, 0, 14'h0013, 32'h0000_0080, 3'b000);
        op(0, 1, 14'h0010, 32'h0, 3'b010);
        op(0, 1, 14'h0013, 32'h0, 3'b100);
        op(0, 1, 14'h0013, 32'h0, 3'b000);
        op(0, 1, 14'h0011, 32'h0, 3'b101);
        op(0, 1, 14'h1010, 32'h0, 3'b010);
        op(1, 0, 14'h2000, 32'h0000_00A5, 3'b010);
        op(0, 1, 14'h2000, 32'h0, 3'b010);
        op(0, 1, 14'h0000, 32'h0, 3'b010);

        op(1, 0, 14'h0020, 32'hAAAA_5555, 3'b010);
        @(negedge clk);
        bus.addr = 14'h0020;
        bus.write_data = 32'h1234_5678;
        bus.sign_mask = 3'b010;
        bus.memwrite = 1'b1;
        #1;
        chk("abort_req_stall", {31'b0, bus.clk_stall}, 32'h1);
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_write_stall", {31'b0, bus.clk_stall}, 32'h1);
        reset = 1'b1;
        #1;
        chk("abort_reset_stall", {31'b0, bus.clk_stall}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_m = '0;
        led_m = '0;
        @(negedge clk);
        chk("abort_read_data", bus.read_data, 32'h0);
        chk("abort_led", {24'b0, bus.led}, 32'h0);
        chk("abort_idle_stall", {31'b0, bus.clk_stall}, 32'h0);
        op(0, 1, 14'h0020, 32'h0, 3'b010);

        op(1, 0, 14'h0004, 32'h0102_0304, 3'b010);
        op(1, 1, 14'h0004, 32'h0000_0055, 3'b000);
        op(0, 1, 14'h0004, 32'h0, 3'b010);

        for (int i = 0; i < 16; i++) op(1, 0, 14'(i * 4), $urandom, 3'b010);
        for (int i = 0; i < 40; i++) begin
            logic [13:0] a;
            bit          w;
            a = 14'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a[13] = 1'b1;
            if ($urandom_range(0, 3) == 0) a[12] = 1'b1;
            w = 1'($urandom_range(0, 1));
            op(w, w ? 1'($urandom_range(0, 1)) : 1'b1, a, $urandom, 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port: addr  input  14  byte address from the CPU EX stage.
REQ-005 SHALL have port: write_data  input  32  store data, right-aligned.
REQ-006 SHALL have port: memwrite  input  1  store request.
REQ-007 SHALL have port: memread  input  1  load request.
REQ-008 SHALL have port: sign_mask  input  3  encoding: bit2 = sign-extend; bits[1:0] = 00 byte, 01 half, 1x word.
REQ-009 SHALL have port: read_data  output  32  load result, extended per sign_mask.
REQ-010 SHALL have port: clk_stall  output  1  CPU must hold its pipeline while high.
REQ-011 SHALL have port: misaligned  output  1  one-cycle pulse when an access is misaligned.
REQ-012 SHALL have port: led  output  8  memory-mapped LED register.
REQ-013 SHALL have parameter: WORDS, default 1024, number of 32-bit RAM words.

Function
REQ-014 SHALL hold a single-port synchronous RAM of WORDS x 32, indexed by addr[11:2]; addr[13]=1 selects the LED register at 0x2000.
REQ-015 SHALL implement an FSM with states IDLE, READ, MERGE, WRITE.
REQ-016 SHALL, in IDLE with memread or memwrite high, latch addr, write_data, sign_mask and the op, then enter READ.
REQ-017 SHALL drive clk_stall combinationally: high in the request cycle (IDLE with a request) and in every non-IDLE state.
REQ-018 SHALL, in READ, issue the RAM read of the latched word; the word is valid in MERGE.
REQ-019 SHALL, for a load in MERGE, register read_data and return to IDLE. Total stall is 3 cycles; read_data is valid in the first IDLE cycle and held until the next load completes.
REQ-020 SHALL, for a load, select the byte from addr[1:0] or the halfword from addr[1], then zero-extend, or sign-extend when bit2=1.
REQ-021 SHALL, for a store in MERGE, merge write_data into the read word (byte lane addr[1:0], half lane addr[1], or the full word), then enter WRITE.
REQ-022 SHALL, in WRITE, commit the merged word to RAM and return to IDLE; total stall is 4 cycles.
REQ-023 SHALL, when memread and memwrite are both high, treat the request as a store only.
REQ-024 SHALL flag a half access with addr[0]=1, or a word access with addr[1:0]!=0, as misaligned: pulse misaligned in the request cycle, force the low address bits to 0 and perform the access.
REQ-025 SHALL, when addr[13]=1, skip the RAM access: a store writes write_data[7:0] to led; a load returns {24'b0, led}, with the same cycle counts.
REQ-026 SHALL ignore addr[12] when addr[13]=0 (aliasing is allowed).
REQ-027 SHALL not sample new requests while not in IDLE.

Reset
REQ-028 SHALL, on reset, force state=IDLE, read_data=0, led=0 and misaligned=0.
REQ-029 SHALL keep clk_stall low in any cycle where reset is high.
REQ-030 SHALL abort any in-flight operation on reset with no RAM write committed; RAM contents are not cleared.

Structure
REQ-031 SHALL place the FSM state encoding, the size codes (00/01/1x) and the LED address constant in the shared rv32i defines include.
REQ-032 SHALL use one sub-module, data_mem_lane_merge: a combinational byte/half/word merge (store) and extract/extend (load) unit.

Verification
REQ-033 SHALL cover: store word 0xDEADBEEF @0x0010, then load word @0x0010 -> clk_stall high for 4 then 3 cycles; read_data=0xDEADBEEF.
REQ-034 SHALL cover: store byte 0x80 @0x0013 over 0x11223344, then load byte signed @0x0013 -> word 0x80223344; read_data=0xFFFFFF80, and 0x00000080 when unsigned.
REQ-035 SHALL cover: load half signed @0x0011 -> misaligned pulses for 1 cycle; data is taken from 0x0010 half 0x3344, giving read_data=0x00003344.
REQ-036 SHALL cover: store 0x000000A5 @0x2000 -> led=0xA5; a load @0x2000 returns 0x000000A5; RAM word 0 is unchanged.
REQ-037 SHALL cover: reset asserted in the WRITE cycle of a store 0x12345678 @0x0020 -> a later load @0x0020 returns the prior value; clk_stall is low during reset.
REQ-038 SHALL cover: memread=memwrite=1 store 0x55 byte @0x0004 -> store performed, read_data unchanged, stall of 4 cycles.
